// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller (mc_ctrl, mc_aludec).
// ERROR state exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR
    } state_t;
`else
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;
`endif

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field
// to the 3-bit ALU control code.
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style Moore controller with stretchable memory states.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky ERROR state.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic        pcen,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       wait_done;
    aluop_t     aluop;

    assign wait_done = (wait_cnt == WAIT_LAST);

    // Counter restarts at zero on every state change, so each stretched state
    // sees exactly 1+MEM_WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (wait_done) state <= DECODE;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        default:      state <= ERROR;
`else
                        default:      state <= FETCH;
`endif
                    endcase
                end
                MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (wait_done) state <= MEMWB;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
                MEMWR: begin
                    if (wait_done) state <= FETCH;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
                EXEC:   state <= ALUWB;
                ADDIEX: state <= ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                ERROR:  state <= ERROR;
`endif
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs decode from registered state; reset masks them immediately.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        pcen     = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        if (!rst) begin
            case (state)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = wait_done;
                    pcen    = wait_done;
                end
                DECODE: alusrcb = 2'b11;
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = wait_done;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
                BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = 2'b01;
                    pcen    = zero;
                end
                JUMP: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = !rst && (state == ERROR);
`else
    assign illegal = 1'b0;
`endif

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: two instances (MEM_WAIT=0 and 2) compared cycle by
// cycle against per-instruction output sequences built from the instruction rules.
module tb_mc_ctrl;

    typedef logic [15:0] vec_t;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [5:0]  op [2];
    logic [5:0]  funct [2];
    logic        zero [2];
    logic        iord [2], memwrite [2], irwrite [2], regdst [2];
    logic        memtoreg [2], regwrite [2], alusrca [2], pcen [2];
    logic [1:0]  alusrcb [2], pcsrc [2];
    logic [2:0]  alucontrol [2];
    logic        illegal [2];
    vec_t        vec [2];

    int n_chk = 0;
    int n_err = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_ctrl #(.MEM_WAIT(g * 2)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .op         (op[g]),
            .funct      (funct[g]),
            .zero       (zero[g]),
            .iord       (iord[g]),
            .memwrite   (memwrite[g]),
            .irwrite    (irwrite[g]),
            .regdst     (regdst[g]),
            .memtoreg   (memtoreg[g]),
            .regwrite   (regwrite[g]),
            .alusrca    (alusrca[g]),
            .pcen       (pcen[g]),
            .alusrcb    (alusrcb[g]),
            .pcsrc      (pcsrc[g]),
            .alucontrol (alucontrol[g]),
            .illegal    (illegal[g])
        );
        assign vec[g] = {iord[g], memwrite[g], irwrite[g], regdst[g], memtoreg[g],
                         regwrite[g], alusrca[g], pcen[g], alusrcb[g], pcsrc[g],
                         alucontrol[g], illegal[g]};
    end

    task automatic chk(input string tag, input vec_t act, input vec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic io, mw, ir, rd, m2r, rw, sa, pe,
                                input logic [1:0] sb, ps, input logic [2:0] ct,
                                input logic il);
        return {io, mw, ir, rd, m2r, rw, sa, pe, sb, ps, ct, il};
    endfunction

    function automatic logic [2:0] fn_ctl(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o == 6'h23 || o == 6'h2B || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02;
    endfunction

    // Expected per-cycle output vector for one whole instruction.
    task automatic build(input int mw, input logic [5:0] o, f, input logic z);
        exp_q.delete();
        for (int i = 0; i <= mw; i++)
            exp_q.push_back(mk(0, 0, i == mw, 0, 0, 0, 0, i == mw, 2'b01, 2'b00, 3'b010, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
        case (o)
            6'h23: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010, 0));
                for (int i = 0; i <= mw; i++)
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h2B: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010, 0));
                for (int i = 0; i <= mw; i++)
                    exp_q.push_back(mk(1, i == mw, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h00: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, fn_ctl(f), 0));
                exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h04: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, z, 2'b00, 2'b01, 3'b110, 0));
            6'h08: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h02: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 3'b010, 0));
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                repeat (10) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1));
`endif
            end
        endcase
    endtask

    // Drive one instruction and check ncyc cycles of it (ncyc<0: the whole instruction).
    task automatic run(input int d, input logic [5:0] o, f, input logic z, input int ncyc);
        int n;
        build(d * 2, o, f, z);
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                op[d] = o;
                funct[d] = f;
                zero[d] = z;
            end
            #1;
            chk($sformatf("d%0d_op%02h_f%02h_z%0d_c%0d", d, o, f, z, i), vec[d], exp_q[i]);
        end
    endtask

    // Assert reset at a negedge, hold for 'hold' edges, release just after an edge
    // so the following cycle is the first FETCH.
    task automatic do_reset(input int d, input int hold);
        @(negedge clk);
        rst[d] = 1'b1;
        #1;
        chk($sformatf("d%0d_rst_out", d), vec[d], 16'h0004);
        repeat (hold) @(posedge clk);
        #1 rst[d] = 1'b0;
    endtask

    task automatic random_block(input int d, input int cnt);
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        logic [5:0] o, f;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int k = 0; k < cnt; k++) begin
            int r;
            r = $urandom_range(0, 6);
            if (r < 6) o = ops[r];
            else begin
                o = 6'($urandom_range(0, 63));
                while (is_legal(o)) o = 6'($urandom_range(0, 63));
            end
            r = $urandom_range(0, 5);
            f = (r < 5) ? fns[r] : 6'($urandom_range(0, 63));
            run(d, o, f, 1'($urandom_range(0, 1)), -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!is_legal(o)) do_reset(d, 1);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            op[d] = 6'h00;
            funct[d] = 6'h20;
            zero[d] = 1'b0;
        end
        repeat (3) @(posedge clk);

        // MEM_WAIT=0 instance
        do_reset(0, 2);
        run(0, 6'h23, 6'h20, 1'b0, -1);
        run(0, 6'h00, 6'h2A, 1'b0, -1);
        run(0, 6'h04, 6'h20, 1'b1, -1);
        run(0, 6'h04, 6'h20, 1'b0, -1);
        run(0, 6'h08, 6'h20, 1'b0, -1);
        run(0, 6'h02, 6'h20, 1'b0, -1);
        run(0, 6'h3F, 6'h20, 1'b0, -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        do_reset(0, 1);
`endif
        run(0, 6'h2B, 6'h20, 1'b0, -1);
        run(0, 6'h23, 6'h20, 1'b0, 3);
        do_reset(0, 1);
        run(0, 6'h00, 6'h25, 1'b0, -1);
        random_block(0, 30);

        // MEM_WAIT=2 instance
        do_reset(1, 2);
        run(1, 6'h2B, 6'h20, 1'b0, -1);
        run(1, 6'h23, 6'h20, 1'b0, -1);
        run(1, 6'h00, 6'h24, 1'b1, -1);
        run(1, 6'h3F, 6'h20, 1'b0, -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        do_reset(1, 1);
`endif
        random_block(1, 30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
